// File: rtl/lc_en_gate.sv
// rtl/lc_en_gate.sv - lifecycle enable qualifier with debounce, secret-wipe handshake and sticky error
// All outputs come from registers or decoded state, so no input ever reaches an output combinationally.
module lc_en_gate #(
   parameter int StableCycles  = 3,
   parameter int InvalidCycles = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [3:0] lc_en_i,
   input  logic       clr_ack_i,
   output logic       en_o,
   output logic       clr_req_o,
   output logic       err_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      ST_DIS = 3'd0,
      ST_ARM = 3'd1,
      ST_ENA = 3'd2,
      ST_CLR = 3'd3,
      ST_ERR = 3'd4
   } state_t;

   localparam logic [3:0] LP_ON     = 4'b0101;
   localparam logic [3:0] LP_OFF    = 4'b1010;
   localparam logic [3:0] LP_STABLE = 4'(StableCycles);
   localparam logic [3:0] LP_INV    = 4'(InvalidCycles);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_scnt, w_scnt_nxt, w_scnt_inc;
   logic [3:0] r_icnt, w_icnt_nxt;
   logic       r_clr_req, w_clr_nxt;
   logic       w_on, w_off, w_inv;

   assign w_on       = (lc_en_i == LP_ON);
   assign w_off      = (lc_en_i == LP_OFF);
   assign w_inv      = !w_on && !w_off;
   assign w_scnt_inc = (r_scnt >= LP_STABLE) ? LP_STABLE : r_scnt + 4'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_scnt_nxt  = 4'd0;
      w_clr_nxt   = r_clr_req;
      if (!w_inv)
         w_icnt_nxt = 4'd0;
      else if (r_icnt >= LP_INV)
         w_icnt_nxt = LP_INV;
      else
         w_icnt_nxt = r_icnt + 4'd1;

      case (r_state)
         ST_DIS: begin
            if (w_on) begin
               w_scnt_nxt  = 4'd1;
               w_state_nxt = (LP_STABLE == 4'd1) ? ST_ENA : ST_ARM;
            end
         end
         ST_ARM: begin
            if (w_on) begin
               w_scnt_nxt = w_scnt_inc;
               if (w_scnt_inc == LP_STABLE)
                  w_state_nxt = ST_ENA;
            end else if (w_off) begin
               w_state_nxt = ST_DIS;
            end
         end
         ST_ENA: begin
            if (w_on) begin
               w_scnt_nxt = LP_STABLE;
            end else begin
               w_state_nxt = ST_CLR;
               w_clr_nxt   = 1'b1;
            end
         end
         ST_CLR: begin
            w_clr_nxt = 1'b1;
            if (clr_ack_i) begin
               w_state_nxt = ST_DIS;
               w_clr_nxt   = 1'b0;
            end
         end
         ST_ERR: begin
            w_clr_nxt = r_clr_req && !clr_ack_i;
         end
         default: begin
            w_state_nxt = ST_ERR;
            w_clr_nxt   = 1'b1;
         end
      endcase

      // Encoding fault wins over everything; an ack landing on this edge still completes the wipe.
      if (w_icnt_nxt == LP_INV && r_state != ST_ERR) begin
         w_state_nxt = ST_ERR;
         w_scnt_nxt  = 4'd0;
         w_clr_nxt   = !(r_clr_req && clr_ack_i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_DIS;
         r_scnt    <= 4'd0;
         r_icnt    <= 4'd0;
         r_clr_req <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_scnt    <= w_scnt_nxt;
         r_icnt    <= w_icnt_nxt;
         r_clr_req <= w_clr_nxt;
      end
   end

   assign en_o      = (r_state == ST_ENA);
   assign err_o     = (r_state == ST_ERR);
   assign clr_req_o = r_clr_req;
   assign state_o   = r_state;

endmodule

// File: doc/lc_en_gate.md
LC_EN_GATE -- requirements
Module: lc_en_gate

Interface
REQ-001 SHALL have parameter StableCycles, default 3, legal range 1..15: consecutive On samples required before enabling.
REQ-002 SHALL have parameter InvalidCycles, default 2, legal range 1..15: consecutive invalid samples required before fatal error.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port lc_en_i, input, 4 bits: one already-synchronized lifecycle enable copy; encodings On=4'b0101, Off=4'b1010, all other values Invalid.
REQ-006 SHALL have port clr_ack_i, input, 1 bit: downstream acknowledges the secret-state wipe.
REQ-007 SHALL have port en_o, output, 1 bit: qualified enable to the consuming logic.
REQ-008 SHALL have port clr_req_o, output, 1 bit: request to wipe downstream secret state.
REQ-009 SHALL have port err_o, output, 1 bit: sticky fatal encoding error.
REQ-010 SHALL have port state_o, output, 3 bits: current FSM state code for debug.

Function
REQ-011 SHALL implement an FSM with states Disabled=3'd0, Arming=3'd1, Enabled=3'd2, Clearing=3'd3, Error=3'd4; unused codes SHALL go to Error on the next edge.
REQ-012 SHALL drive all outputs from registers or decoded current state; no combinational path from any input to any output.
REQ-013 SHALL keep a 4-bit stable counter scnt counting consecutive On samples, saturating at StableCycles.
REQ-014 SHALL keep a 4-bit invalid counter icnt counting consecutive Invalid samples; any On or Off sample clears it to 0.
REQ-015 Disabled: On -> Arming with scnt=1; if StableCycles==1 -> Enabled directly; Off -> stay, scnt=0.
REQ-016 Arming: On increments scnt and goes to Enabled on the sample where scnt reaches StableCycles; Off -> Disabled, scnt=0; Invalid -> stay Arming, scnt=0.
REQ-017 en_o SHALL be 1 exactly when state is Enabled; with StableCycles=N, en_o rises the cycle after the N-th consecutive On sample.
REQ-018 Enabled: any non-On sample (Off or Invalid) -> Clearing; en_o low from the next cycle.
REQ-019 Clearing: clr_req_o=1; stay until clr_ack_i is sampled 1, then -> Disabled with clr_req_o=0 the next cycle; lc_en_i On SHALL NOT re-arm before the ack.
REQ-020 clr_ack_i sampled while clr_req_o=0 SHALL be ignored.
REQ-021 From any state, icnt reaching InvalidCycles SHALL force Error; this takes priority over every other transition on the same edge.
REQ-022 Error: en_o=0, err_o=1; clr_req_o=1 until the first clr_ack_i, then 0; Error SHALL be terminal until reset.
REQ-023 Entering Error from Enabled SHALL still raise clr_req_o in the first Error cycle.
REQ-024 Entering Error directly from Clearing, with the ack pending, SHALL keep clr_req_o high without a low cycle.
REQ-025 err_o SHALL never deassert except by reset.

Reset
REQ-026 Asserting rst_i SHALL immediately, without waiting for a clock edge, force state Disabled, scnt=0, icnt=0, en_o=0, clr_req_o=0, err_o=0, state_o=3'd0.
REQ-027 Reset asserted mid-Clearing SHALL drop clr_req_o without requiring an ack.
REQ-028 After rst_i deasserts, the first transition SHALL occur on the next rising clk_i edge.

Verification
REQ-029 Arm: defaults, lc_en_i=0101 held from cycle 0 -> en_o=1 from cycle 3, state_o=2.
REQ-030 Interrupted arm: sample sequence 0101,0101,1010,0101,0101,0101 -> en_o stays 0 through the first five samples and rises after the sixth.
REQ-031 Clear handshake: Enabled, then lc_en_i=1010 -> en_o=0 and clr_req_o=1 next cycle; On ignored; clr_ack_i=1 for one cycle -> state_o=0 and clr_req_o=0.
REQ-032 Glitch tolerance: Enabled, one 0111 sample followed by 0101 -> Clearing and en_o=0, but err_o stays 0.
REQ-033 Fatal error: two consecutive 0000 samples in any state -> err_o=1 and state_o=4 on the next edge; err_o remains 1 under any later lc_en_i until rst_i=1.
REQ-034 Async reset: rst_i pulsed mid-Clearing, between clock edges -> all outputs 0 before the next clk_i edge.
